// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle for sysid_regs: word address, read/write strobes,
// byte-enabled write data and a fixed-latency registered read return.
interface sysid_regs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regs.sv
// System-ID slave: ID/timestamp/version words, byte-writable scratch and (with
// SYSID_UPTIME_EN) a 2-word uptime counter. Read latency 1, no waitrequest.
module sysid_regs #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 3,
    parameter logic [31:0]           SYSTEM_ID     = 32'd7,
    parameter logic [31:0]           TIMESTAMP     = 32'd1382619795,
    parameter logic [31:0]           VERSION       = 32'h0002_0000,
    parameter logic [DATA_WIDTH-1:0] SCRATCH_RESET = '0
) (
    input  logic       clock,
    input  logic       reset,
    sysid_regs_if.slave bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] A_ID        = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_TIMESTAMP = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_VERSION   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH   = ADDR_WIDTH'(3);
`ifdef SYSID_UPTIME_EN
    localparam logic [ADDR_WIDTH-1:0] A_UP_LO     = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_UP_HI     = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_CONTROL   = ADDR_WIDTH'(6);
    // Bit 0 of VERSION advertises the uptime counter to software.
    localparam logic [31:0] VERSION_WORD = VERSION | 32'd1;
`else
    localparam logic [31:0] VERSION_WORD = VERSION & ~32'd1;
`endif

    logic [DATA_WIDTH-1:0] scratch;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  scratch_wr;

    assign scratch_wr = bus.write && (bus.address == A_SCRATCH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= SCRATCH_RESET;
        end else if (scratch_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.byteenable[i]) begin
                    scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

`ifdef SYSID_UPTIME_EN
    logic [2*DATA_WIDTH-1:0] uptime;
    logic [DATA_WIDTH-1:0]   uptime_hi_shadow;
    logic                    ctrl_freeze;
    logic                    ctrl_wr;
    logic                    ctrl_clear;
    logic                    lo_read;

    assign ctrl_wr    = bus.write && (bus.address == A_CONTROL) && bus.byteenable[0];
    assign ctrl_clear = ctrl_wr && bus.writedata[0];
    assign lo_read    = bus.read && (bus.address == A_UP_LO);

    // Clear wins over both increment and freeze; a freeze written in the same
    // cycle only affects the following edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uptime           <= '0;
            uptime_hi_shadow <= '0;
            ctrl_freeze      <= 1'b0;
        end else begin
            if (ctrl_clear) begin
                uptime <= '0;
            end else if (!ctrl_freeze) begin
                uptime <= uptime + 1'b1;
            end
            if (ctrl_wr) begin
                ctrl_freeze <= bus.writedata[1];
            end
            // Latch the high half alongside the low-word read so the pair is coherent.
            if (lo_read) begin
                uptime_hi_shadow <= uptime[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (bus.address)
            A_ID:        rd_word = DATA_WIDTH'(SYSTEM_ID);
            A_TIMESTAMP: rd_word = DATA_WIDTH'(TIMESTAMP);
            A_VERSION:   rd_word = DATA_WIDTH'(VERSION_WORD);
            A_SCRATCH:   rd_word = scratch;
`ifdef SYSID_UPTIME_EN
            A_UP_LO:     rd_word = uptime[DATA_WIDTH-1:0];
            A_UP_HI:     rd_word = uptime_hi_shadow;
            A_CONTROL:   rd_word = DATA_WIDTH'({ctrl_freeze, 1'b0});
`endif
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= rd_word;
            end
        end
    end
endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
- Parametrised system-identification slave on the Avalon-MM control bus; successor to the 1-bit-address ID/timestamp slave.
- Adds:
  - registered read path with readdatavalid
  - version word
  - byte-writable scratch register
  - free-running uptime counter with coherent 2-word read, clear and freeze controls
- Software uses it to confirm that the loaded FPGA image matches the BSP, and as a bus sanity check.

Parameters:
- DATA_WIDTH, 32, bus width; multiple of 8, minimum 32. ID words are zero-extended to this width.
- ADDR_WIDTH, 3, word-address width; minimum 3.
- SYSTEM_ID, 7, value returned at word 0.
- TIMESTAMP, 1382619795, build time (Unix seconds) returned at word 1.
- VERSION, 32'h0002_0000, block/image version returned at word 2.
- SCRATCH_RESET, 0, reset value of the scratch register.

Ports:
- clock, input, 1, sole clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- address, input, ADDR_WIDTH, word address.
- read, input, 1, read strobe, valid for one cycle per transfer.
- write, input, 1, write strobe.
- writedata, input, DATA_WIDTH, write data.
- byteenable, input, DATA_WIDTH/8, byte lanes for writes.
- readdata, output, DATA_WIDTH, registered read data.
- readdatavalid, output, 1, high exactly one cycle after each accepted read.

Behaviour:
- **Reset:** asynchronous and active-high, so reset clears state immediately.
  - readdata=0, readdatavalid=0, scratch=SCRATCH_RESET, uptime=0, uptime_hi_shadow=0, ctrl_freeze=0.
  - Reset asserted mid-transfer drops that transfer. No readdatavalid pulse is generated for it.
- **Handshakes:** no waitrequest; every read and write is accepted in the cycle it is presented. Read latency is fixed at 1: readdata and readdatavalid are registered from the read cycle. readdata holds its value while readdatavalid=0.
- **Register map** (word address):
  - 0 ID, RO: SYSTEM_ID.
  - 1 TIMESTAMP, RO: TIMESTAMP.
  - 2 VERSION, RO: VERSION.
  - 3 SCRATCH, RW. Each byte lane is updated only where byteenable=1. byteenable=0 with write=1 leaves the register unchanged.
  - 4 UPTIME_LO, RO. Returns uptime[DATA_WIDTH-1:0]. In the same cycle it captures uptime[2*DATA_WIDTH-1:DATA_WIDTH] into uptime_hi_shadow.
  - 5 UPTIME_HI, RO. Returns uptime_hi_shadow, never the live high word.
  - 6 CONTROL, RW:
    - bit0 CLEAR: write-1 pulse, self-clearing, reads 0.
    - bit1 FREEZE: level.
    - Other bits read 0.
    - Writes apply only when byteenable[0]=1.
  - 7 and above: reads return 0, writes are ignored.
- **Uptime counter:** 2*DATA_WIDTH bits, +1 every clock while FREEZE=0.
  - Wraps from all-ones to 0 with no flag.
  - A CLEAR write forces the counter to 0 on the next edge. CLEAR has priority over increment and over FREEZE. Writing CLEAR=1 together with FREEZE=1 leaves the counter at 0 and held.
- **Same-cycle read and write:** if read and write target the same address in one cycle, the write takes effect at that edge and the read returns the pre-write value.
- **Read of CONTROL:** returns the current FREEZE bit.
- **Address decode:** uses the full ADDR_WIDTH; no aliasing.

Optional Feature:
- Macro: SYSID_UPTIME_EN.
- Defined: uptime counter, shadow register and CONTROL register are implemented as described above.
- Undefined:
  - No counter or shadow flops are instantiated.
  - Words 4, 5 and 6 read 0 and ignore writes.
  - VERSION bit 0 is forced to 0, and is 1 when the feature is present. Software uses this bit to detect the counter.
  - Words 0–3 behave identically in both builds.

Test Plan:
- Reset, then read words 0, 1, 2, 7 back-to-back → readdata 7, 1382619795, 32'h0002_0001, 0. Each readdatavalid appears exactly 1 cycle after its read. Four consecutive readdatavalid cycles, no gaps.
- Write 0xAABBCCDD to word 3 with byteenable 4'b0101 from SCRATCH_RESET=0, then read → 0x00BB00DD. Same-cycle read+write of 0x11111111 to word 3 returns 0x00BB00DD; the following read returns 0x11111111.
- Coherent read across the boundary: force uptime to 0x0000_0000_FFFF_FFFE (FREEZE=0), read word 4 → 0xFFFFFFFE. Reading word 5 several cycles later → 0 (shadow), not the live value 1.
- Write CONTROL=0x2 (freeze), wait 10 cycles, read words 4 twice → identical values. Write CONTROL=0x3 → next-cycle counter 0 and held. Read CONTROL → 0x2.
- Wrap: force uptime to all-ones, FREEZE=0 → next cycle 0, no other side effects.
- Assert reset asynchronously (between clock edges) while a read is in flight → readdatavalid never pulses for it, all state at reset values. With SYSID_UPTIME_EN undefined, words 4/5/6 read 0 and VERSION reads 32'h0002_0000.
